// File: rtl/bullet_ctrl.sv
// Player projectile engine: spawns one bullet on a fire press, moves it per frame tick,
// pulses getshot on a target hit. Optional build macro BULLET_PIERCE_EN lets bullets pass through.
module bullet_ctrl #(
    parameter int NUM_TARGETS     = 6,
    parameter int SPEED           = 4,
    parameter int BULLET_SIZE     = 8,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     restart,
    input  logic                     frame_clk,
    input  logic                     fire,
    input  logic [9:0]               man_x,
    input  logic [9:0]               man_y,
    input  logic [1:0]               direction,
    input  logic [1:0]               inmap,
    input  logic [10*NUM_TARGETS-1:0] target_x,
    input  logic [10*NUM_TARGETS-1:0] target_y,
    input  logic [NUM_TARGETS-1:0]   target_on,
    output logic [NUM_TARGETS-1:0]   getshot,
    output logic                     bullet_active,
    output logic [9:0]               bullet_x,
    output logic [9:0]               bullet_y,
    output logic [1:0]               bullet_dir
);

    localparam int CD_W = $clog2(COOLDOWN_FRAMES + 2);
    localparam logic [CD_W-1:0] CD_INIT = CD_W'(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);
    localparam logic [9:0]  STEP  = 10'(SPEED);
    localparam logic [10:0] BS11  = 11'(BULLET_SIZE);
    localparam logic [9:0]  SCR_W = 10'(SCREEN_W);
    localparam logic [9:0]  SCR_H = 10'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, FLY, CHECK, COOL} state_t;

    state_t              state;
    logic                frame_prev;
    logic                tick;
    logic                fire_prev;
    logic [CD_W-1:0]     cooldown;
`ifdef BULLET_PIERCE_EN
    logic [NUM_TARGETS-1:0] hit_mask;
`endif

    logic                   press;
    logic [9:0]             spawn_x, spawn_y;
    logic                   spawn_ok;
    logic [9:0]             next_x, next_y;
    logic [NUM_TARGETS-1:0] hit_next;
    logic                   offscreen;

    // Box overlap evaluated at 11 bits so a bullet near 1023 never wraps into a hit.
    function automatic logic overlap(input logic [9:0] bx, input logic [9:0] by,
                                     input logic [9:0] tx, input logic [9:0] ty);
        overlap = ({1'b0, bx} + BS11 > {1'b0, tx}) && ({1'b0, bx} < {1'b0, tx} + 11'd32) &&
                  ({1'b0, by} + BS11 > {1'b0, ty}) && ({1'b0, by} < {1'b0, ty} + 11'd32);
    endfunction

    function automatic logic [NUM_TARGETS-1:0] lowest_one(input logic [NUM_TARGETS-1:0] v);
        lowest_one = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_one    = '0;
                lowest_one[i] = 1'b1;
            end
        end
    endfunction

    assign press     = tick & fire & ~fire_prev;
    assign offscreen = (bullet_x >= SCR_W) || (bullet_y >= SCR_H);

    always_comb begin
        spawn_x  = man_x + 10'd12;
        spawn_y  = man_y - 10'd8;
        spawn_ok = (man_y >= 10'd8);
        case (direction)
            2'b00: begin spawn_x = man_x + 10'd12; spawn_y = man_y - 10'd8;  spawn_ok = (man_y >= 10'd8); end
            2'b01: begin spawn_x = man_x + 10'd32; spawn_y = man_y + 10'd12; spawn_ok = 1'b1; end
            2'b10: begin spawn_x = man_x - 10'd8;  spawn_y = man_y + 10'd12; spawn_ok = (man_x >= 10'd8); end
            2'b11: begin spawn_x = man_x + 10'd12; spawn_y = man_y + 10'd32; spawn_ok = 1'b1; end
        endcase
    end

    always_comb begin
        next_x = bullet_x;
        next_y = bullet_y;
        case (bullet_dir)
            2'b00: next_y = bullet_y - STEP;
            2'b01: next_x = bullet_x + STEP;
            2'b10: next_x = bullet_x - STEP;
            2'b11: next_y = bullet_y + STEP;
        endcase
        for (int i = 0; i < NUM_TARGETS; i++)
            hit_next[i] = target_on[i] & overlap(next_x, next_y, target_x[10*i +: 10], target_y[10*i +: 10]);
    end

    // Hits are judged on the post-move position while entering CHECK, so getshot is a
    // register that is high exactly for the CHECK cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            frame_prev    <= 1'b0;
            tick          <= 1'b0;
            fire_prev     <= 1'b0;
            cooldown      <= '0;
            getshot       <= '0;
            bullet_active <= 1'b0;
            bullet_x      <= '0;
            bullet_y      <= '0;
            bullet_dir    <= 2'b00;
`ifdef BULLET_PIERCE_EN
            hit_mask      <= '0;
`endif
        end else if (restart) begin
            state         <= IDLE;
            frame_prev    <= 1'b0;
            tick          <= 1'b0;
            fire_prev     <= 1'b0;
            cooldown      <= '0;
            getshot       <= '0;
            bullet_active <= 1'b0;
            bullet_x      <= '0;
            bullet_y      <= '0;
            bullet_dir    <= 2'b00;
`ifdef BULLET_PIERCE_EN
            hit_mask      <= '0;
`endif
        end else begin
            frame_prev <= frame_clk;
            tick       <= frame_clk & ~frame_prev;
            if (tick)
                fire_prev <= fire;
            getshot <= '0;
            if (inmap != 2'b00) begin
                state         <= IDLE;
                bullet_active <= 1'b0;
                cooldown      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (press && spawn_ok) begin
                            bullet_x      <= spawn_x;
                            bullet_y      <= spawn_y;
                            bullet_dir    <= direction;
                            bullet_active <= 1'b1;
                            state         <= FLY;
`ifdef BULLET_PIERCE_EN
                            hit_mask      <= '0;
`endif
                        end
                    end
                    FLY: begin
                        if (tick) begin
                            bullet_x <= next_x;
                            bullet_y <= next_y;
                            state    <= CHECK;
`ifdef BULLET_PIERCE_EN
                            getshot  <= hit_next & ~hit_mask;
`else
                            getshot  <= lowest_one(hit_next);
`endif
                        end
                    end
                    CHECK: begin
`ifdef BULLET_PIERCE_EN
                        hit_mask <= hit_mask | getshot;
                        if (offscreen) begin
`else
                        if ((|getshot) || offscreen) begin
`endif
                            state         <= COOL;
                            bullet_active <= 1'b0;
                            cooldown      <= CD_INIT;
                        end else begin
                            state <= FLY;
                        end
                    end
                    COOL: begin
                        if (cooldown == '0)
                            state <= IDLE;
                        else if (tick)
                            cooldown <= cooldown - CD_ONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bullet_ctrl.sv
// Self-checking bench for bullet_ctrl: per-cycle comparison against a frame-level model
// plus hand-computed expectations for the directed scenarios.
module tb_bullet_ctrl;

    localparam int N        = 6;
    localparam int SPEED    = 4;
    localparam int BS       = 8;
    localparam int COOLDOWN = 15;

    logic Clk = 1'b0, Reset_n = 1'b0, restart = 1'b0, frame_clk = 1'b0, fire = 1'b0;
    logic [9:0] man_x = '0, man_y = '0;
    logic [1:0] direction = '0, inmap = '0;
    logic [10*N-1:0] target_x = '0, target_y = '0;
    logic [N-1:0] target_on = '0;
    logic [N-1:0] getshot;
    logic bullet_active;
    logic [9:0] bullet_x, bullet_y;
    logic [1:0] bullet_dir;

    bullet_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .restart(restart), .frame_clk(frame_clk), .fire(fire),
        .man_x(man_x), .man_y(man_y), .direction(direction), .inmap(inmap),
        .target_x(target_x), .target_y(target_y), .target_on(target_on),
        .getshot(getshot), .bullet_active(bullet_active),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_dir(bullet_dir)
    );

    always #5 Clk = ~Clk;
    initial begin
        #3;
        forever #40 frame_clk = ~frame_clk;
    end

    // phase: 0 idle, 1 flying, 2 checking, 3 cooling
    typedef struct {
        int phase, x, y, dir, cd;
        bit fprev, tick, fireprev;
        logic [N-1:0] shot, mask;
    } model_t;

    model_t m;

    function automatic model_t model_init();
        model_t r;
        r.phase = 0; r.x = 0; r.y = 0; r.dir = 0; r.cd = 0;
        r.fprev = 0; r.tick = 0; r.fireprev = 0; r.shot = '0; r.mask = '0;
        return r;
    endfunction

    function automatic model_t step(input model_t c);
        model_t n = c;
        bit press, off;
        int sx, sy, nx, ny, tx, ty;
        logic [N-1:0] hits, low;
        n.tick  = frame_clk && !c.fprev;
        n.fprev = frame_clk;
        press   = c.tick && fire && !c.fireprev;
        if (c.tick) n.fireprev = fire;
        n.shot = '0;
        if (inmap != 2'b00) begin
            n.phase = 0; n.cd = 0;
        end else if (c.phase == 0) begin
            sx = int'(man_x); sy = int'(man_y);
            case (direction)
                2'b00: begin sx = sx + 12; sy = sy - 8;  end
                2'b01: begin sx = sx + 32; sy = sy + 12; end
                2'b10: begin sx = sx - 8;  sy = sy + 12; end
                default: begin sx = sx + 12; sy = sy + 32; end
            endcase
            if (press && sx >= 0 && sy >= 0) begin
                n.x = sx % 1024; n.y = sy % 1024; n.dir = int'(direction);
                n.phase = 1; n.mask = '0;
            end
        end else if (c.phase == 1) begin
            if (c.tick) begin
                nx = c.x; ny = c.y;
                case (c.dir)
                    0: ny = (c.y - SPEED + 1024) % 1024;
                    1: nx = (c.x + SPEED) % 1024;
                    2: nx = (c.x - SPEED + 1024) % 1024;
                    default: ny = (c.y + SPEED) % 1024;
                endcase
                hits = '0;
                for (int i = 0; i < N; i++) begin
                    tx = int'(target_x[10*i +: 10]);
                    ty = int'(target_y[10*i +: 10]);
                    if (target_on[i] && nx + BS > tx && nx < tx + 32 && ny + BS > ty && ny < ty + 32)
                        hits[i] = 1'b1;
                end
                low = '0;
                for (int i = 0; i < N; i++)
                    if (hits[i] && low == '0) low[i] = 1'b1;
`ifdef BULLET_PIERCE_EN
                n.shot = hits & ~c.mask;
`else
                n.shot = low;
`endif
                n.x = nx; n.y = ny; n.phase = 2;
            end
        end else if (c.phase == 2) begin
            off = (c.x >= 640) || (c.y >= 480);
`ifdef BULLET_PIERCE_EN
            n.mask  = c.mask | c.shot;
            n.phase = off ? 3 : 1;
`else
            n.phase = (off || c.shot != '0) ? 3 : 1;
`endif
            if (n.phase == 3) n.cd = COOLDOWN;
        end else begin
            if (c.cd == 0) n.phase = 0;
            else if (c.tick) n.cd = c.cd - 1;
        end
        return n;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)     m <= model_init();
        else if (restart) m <= model_init();
        else              m <= step(m);
    end

    int vectors = 0, miscompares = 0;
    bit run = 0;
    int spawns = 0, pulses = 0, pulses_this = 0, shot_x = -1, last_x = -1;
    logic [N-1:0] shot_or = '0;
    bit prev_act = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        bit exp_act;
        @(negedge Clk);
        if (Reset_n && run) begin
            exp_act = (m.phase == 1) || (m.phase == 2);
            vectors++;
            if (getshot !== m.shot || bullet_active !== exp_act || int'(bullet_x) != m.x ||
                int'(bullet_y) != m.y || int'(bullet_dir) != m.dir) begin
                miscompares++;
                $display("FAIL cycle t=%0t: got shot=%b act=%b x=%0d y=%0d dir=%0d, expected shot=%b act=%b x=%0d y=%0d dir=%0d",
                         $time, getshot, bullet_active, bullet_x, bullet_y, bullet_dir,
                         m.shot, exp_act, m.x, m.y, m.dir);
            end
        end
        if (bullet_active && !prev_act) begin
            spawns++; pulses_this = 0; shot_or = '0;
        end
        if (bullet_active) last_x = int'(bullet_x);
        if (getshot != '0) begin
            pulses++; pulses_this++; shot_or = shot_or | getshot; shot_x = int'(bullet_x);
        end
        prev_act = bullet_active;
    endtask

    task automatic frames(input int n);
        repeat (n * 8) cyc();
    endtask

    task automatic wait_active(input bit val, input int budget, input string name);
        int k = 0;
        while (bullet_active !== val && k < budget) begin cyc(); k++; end
        if (k >= budget) begin
            vectors++; miscompares++;
            $display("FAIL %s: timeout after %0d cycles, bullet_active=%b wanted %b", name, k, bullet_active, val);
        end
    endtask

    task automatic shoot(input int x, input int y, input int d);
        man_x = 10'(x); man_y = 10'(y); direction = 2'(d);
        fire = 1'b1;
        wait_active(1'b1, 40, "spawn");
        fire = 1'b0;
    endtask

    task automatic set_target(input int i, input int x, input int y);
        target_x[10*i +: 10] = 10'(x);
        target_y[10*i +: 10] = 10'(y);
    endtask

    int s0, p0;

    initial begin
        repeat (3) cyc();
        Reset_n = 1'b1;
        run = 1;
        cyc();
        check("reset_active", int'(bullet_active), 0);
        check("reset_x", int'(bullet_x), 0);
        check("reset_shot", int'(getshot), 0);
        check("reset_dir", int'(bullet_dir), 0);
        frames(2);

        // Long flight right into target 0, then cooldown behaviour.
        set_target(0, 384, 64); target_on = 6'b000001;
        s0 = spawns;
        shoot(100, 64, 1);
        check("s1_spawn_x", int'(bullet_x), 132);
        check("s1_spawn_y", int'(bullet_y), 76);
        check("s1_dir", int'(bullet_dir), 1);
        wait_active(1'b0, 1500, "s1_retire");
        check("s1_pulses", pulses_this, 1);
        check("s1_shot", int'(shot_or), 1);
        check("s1_hit_x", shot_x, 380);
        check("s1_last_x", last_x, 380);
        frames(3);
        fire = 1'b1; frames(2); fire = 1'b0;
        check("cool_press_ignored", spawns, s0 + 1);
        frames(14);
        fire = 1'b1;
        wait_active(1'b1, 40, "after_cool_spawn");
        fire = 1'b0;
        check("after_cool_spawn_cnt", spawns, s0 + 2);
        wait_active(1'b0, 1500, "s1b_retire");
        frames(17);

        // Off the right edge with no live targets.
        target_on = '0;
        p0 = pulses;
        shoot(600, 200, 1);
        check("s2_spawn_x", int'(bullet_x), 632);
        wait_active(1'b0, 200, "s2_retire");
        check("s2_last_x", last_x, 640);
        check("s2_no_pulse", pulses, p0);
        frames(17);

        // Spawns that would need negative coordinates are dropped.
        s0 = spawns;
        man_x = 10'd4; man_y = 10'd200; direction = 2'b10;
        fire = 1'b1; frames(3); fire = 1'b0; frames(2);
        man_x = 10'd100; man_y = 10'd4; direction = 2'b00;
        fire = 1'b1; frames(3); fire = 1'b0; frames(2);
        check("reject_spawns", spawns, s0);
        check("reject_active", int'(bullet_active), 0);

        // Held fire yields a single bullet; re-press during cooldown is ignored.
        s0 = spawns;
        man_x = 10'd600; man_y = 10'd200; direction = 2'b01;
        fire = 1'b1; frames(6);
        fire = 1'b0; frames(2);
        fire = 1'b1; frames(92);
        fire = 1'b0;
        check("held_fire_spawns", spawns, s0 + 1);
        frames(17);

        // Targets 2 and 3 overlap the bullet in the same check; 1 is elsewhere, 4 is dead.
        set_target(1, 200, 100); set_target(2, 200, 300);
        set_target(3, 200, 310); set_target(4, 200, 312);
        target_on = 6'b001110;
        shoot(100, 300, 1);
        check("s5_spawn_y", int'(bullet_y), 312);
        wait_active(1'b0, 1500, "s5_retire");
        check("s5_pulses", pulses_this, 1);
        check("s5_hit_x", shot_x, 196);
`ifdef BULLET_PIERCE_EN
        check("s5_shot", int'(shot_or), 12);
        check("s5_last_x", last_x, 640);
`else
        check("s5_shot", int'(shot_or), 4);
        check("s5_last_x", last_x, 196);
`endif
        target_on = '0;
        frames(17);

        // Asynchronous reset mid-flight.
        shoot(100, 200, 0);
        check("s6_spawn_y", int'(bullet_y), 192);
        frames(3);
        Reset_n = 1'b0;
        #1;
        check("arst_active", int'(bullet_active), 0);
        check("arst_shot", int'(getshot), 0);
        check("arst_x", int'(bullet_x), 0);
        cyc(); cyc();
        Reset_n = 1'b1;
        frames(1);
        check("arst_idle", int'(bullet_active), 0);

        // Synchronous restart mid-flight.
        shoot(100, 100, 3);
        check("s7_spawn_y", int'(bullet_y), 132);
        frames(2);
        restart = 1'b1; cyc(); restart = 1'b0;
        check("restart_active", int'(bullet_active), 0);
        check("restart_y", int'(bullet_y), 0);
        frames(2);

        // Leaving map 00 mid-flight drops the bullet next cycle.
        shoot(100, 200, 1);
        frames(2);
        check("map_flying", int'(bullet_active), 1);
        inmap = 2'b01; cyc();
        check("map_exit_active", int'(bullet_active), 0);
        frames(2);
        inmap = 2'b00;
        frames(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
